// File: rtl/logic_unit_32.sv
// rtl/logic_unit_32.sv - registered bitwise logic unit with result flags
//
// Purpose:
//   Single-cycle execute-stage functional unit. Applies one of eight bitwise
//   functions to a and b, selected by ctl, and registers the result together
//   with zero / all-ones / parity flags. Optional population count output is
//   enabled by defining LU_POPCNT_EN.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   in_valid   in   a, b, ctl valid this cycle
//   a, b       in   WIDTH-bit operands
//   ctl        in   3-bit function select
//                   000 AND, 001 OR, 010 XOR, 011 NOR,
//                   100 NAND, 101 XNOR, 110 ANDN (a & ~b), 111 NOT (~a)
//   out        out  registered result
//   out_valid  out  one-cycle strobe per accepted operation
//   zero       out  registered out == 0
//   ones       out  registered out == all ones
//   parity     out  registered XOR-reduction of out
//   popcnt     out  registered count of ones in out (LU_POPCNT_EN only)

module logic_unit_32 #(
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  input  logic [2:0]               ctl,
  output logic [WIDTH-1:0]         out,
  output logic                     out_valid,
  output logic                     zero,
  output logic                     ones,
`ifdef LU_POPCNT_EN
  output logic                     parity,
  output logic [$clog2(WIDTH):0]   popcnt
`else
  output logic                     parity
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] out_q, out_d;
  logic             valid_q;
  logic             zero_q, zero_d;
  logic             ones_q, ones_d;
  logic             parity_q, parity_d;

  // Combinational function select.
  always_comb begin
    out_d = '0;
    unique case (ctl)
      3'b000:  out_d = a & b;
      3'b001:  out_d = a | b;
      3'b010:  out_d = a ^ b;
      3'b011:  out_d = ~(a | b);
      3'b100:  out_d = ~(a & b);
      3'b101:  out_d = ~(a ^ b);
      3'b110:  out_d = a & ~b;
      3'b111:  out_d = ~a;
      default: out_d = '0;
    endcase
  end

  // Flags are derived from the new result so they update on the same edge.
  always_comb begin
    zero_d   = (out_d == '0);
    ones_d   = (out_d == {WIDTH{1'b1}});
    parity_d = ^out_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q    <= '0;
      valid_q  <= 1'b0;
      zero_q   <= 1'b1;
      ones_q   <= 1'b0;
      parity_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        out_q    <= out_d;
        zero_q   <= zero_d;
        ones_q   <= ones_d;
        parity_q <= parity_d;
      end
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;
  assign zero      = zero_q;
  assign ones      = ones_q;
  assign parity    = parity_q;

`ifdef LU_POPCNT_EN
  logic [CW-1:0] popcnt_q, popcnt_d;

  always_comb begin
    popcnt_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      popcnt_d = popcnt_d + CW'(out_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      popcnt_q <= '0;
    end else if (in_valid) begin
      popcnt_q <= popcnt_d;
    end
  end

  assign popcnt = popcnt_q;
`endif

endmodule

// File: tb/tb_logic_unit_32.sv
// tb/tb_logic_unit_32.sv - directed self-checking bench for logic_unit_32

module tb_logic_unit_32;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  ctl;
  logic [31:0] out;
  logic        out_valid;
  logic        zero;
  logic        ones;
  logic        parity;
`ifdef LU_POPCNT_EN
  logic [5:0]  popcnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic_unit_32 #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .ctl       (ctl),
    .out       (out),
    .out_valid (out_valid),
    .zero      (zero),
    .ones      (ones),
`ifdef LU_POPCNT_EN
    .parity    (parity),
    .popcnt    (popcnt)
`else
    .parity    (parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge, then sample away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; a = 32'hFFFF_FFFF; b = 32'h1234_5678; ctl = 3'b001;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (out !== 32'h0 || out_valid !== 1'b0 || zero !== 1'b1 ||
          ones !== 1'b0 || parity !== 1'b0) begin
        n_fail++;
        $display("FAIL reset cyc%0d: out=%h v=%b z=%b o=%b p=%b, required out=0 v=0 z=1 o=0 p=0",
                 i, out, out_valid, zero, ones, parity);
      end
`ifdef LU_POPCNT_EN
      n_checks++;
      if (popcnt !== 6'd0) begin
        n_fail++;
        $display("FAIL reset_popcnt cyc%0d: got %0d required 0", i, popcnt);
      end
`endif
    end
  endtask

  // First sweep op is presented while rst drops, so it must be captured.
  task automatic test_sweep();
    logic [31:0] exp_tbl [8];
    exp_tbl[0] = 32'h0000_0000; exp_tbl[1] = 32'h0000_0026;
    exp_tbl[2] = 32'h0000_0026; exp_tbl[3] = 32'hFFFF_FFD9;
    exp_tbl[4] = 32'hFFFF_FFFF; exp_tbl[5] = 32'hFFFF_FFD9;
    exp_tbl[6] = 32'h0000_0026; exp_tbl[7] = 32'hFFFF_FFD9;
    rst = 1'b0; in_valid = 1'b1; a = 32'h0000_0026; b = 32'h0;
    for (int i = 0; i < 8; i++) begin
      ctl = 3'(i);
      step();
      n_checks++;
      if (out !== exp_tbl[i] || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL sweep ctl=%0d: out=%h v=%b, required out=%h v=1",
                 i, out, out_valid, exp_tbl[i]);
      end
    end
  endtask

  task automatic test_flags();
    rst = 1'b0; in_valid = 1'b1; a = 32'h0000_0026; b = 32'h0; ctl = 3'b001;
    step();
    n_checks++;
    if (zero !== 1'b0 || ones !== 1'b0 || parity !== 1'b1) begin
      n_fail++;
      $display("FAIL flags_or: z=%b o=%b p=%b, required z=0 o=0 p=1", zero, ones, parity);
    end
`ifdef LU_POPCNT_EN
    n_checks++;
    if (popcnt !== 6'd3) begin
      n_fail++;
      $display("FAIL popcnt_or: got %0d required 3", popcnt);
    end
`endif
    ctl = 3'b100;
    step();
    n_checks++;
    if (zero !== 1'b0 || ones !== 1'b1 || parity !== 1'b0) begin
      n_fail++;
      $display("FAIL flags_nand: z=%b o=%b p=%b, required z=0 o=1 p=0", zero, ones, parity);
    end
`ifdef LU_POPCNT_EN
    n_checks++;
    if (popcnt !== 6'd32) begin
      n_fail++;
      $display("FAIL popcnt_nand: got %0d required 32", popcnt);
    end
`endif
    ctl = 3'b000;
    step();
    n_checks++;
    if (zero !== 1'b1 || ones !== 1'b0 || parity !== 1'b0) begin
      n_fail++;
      $display("FAIL flags_and: z=%b o=%b p=%b, required z=1 o=0 p=0", zero, ones, parity);
    end
  endtask

  task automatic test_nor_zero();
    rst = 1'b0; in_valid = 1'b1; a = 32'h0; b = 32'h0; ctl = 3'b011;
    step();
    n_checks++;
    if (out !== 32'hFFFF_FFFF || ones !== 1'b1 || zero !== 1'b0 || parity !== 1'b0) begin
      n_fail++;
      $display("FAIL nor_zero: out=%h z=%b o=%b p=%b, required out=ffffffff z=0 o=1 p=0",
               out, zero, ones, parity);
    end
  endtask

  task automatic test_mixed();
    logic [2:0]  ctl_tbl [4];
    logic [31:0] exp_tbl [4];
    ctl_tbl[0] = 3'b000; exp_tbl[0] = 32'h00F0_A500;
    ctl_tbl[1] = 3'b010; exp_tbl[1] = 32'hFF00_5AA5;
    ctl_tbl[2] = 3'b110; exp_tbl[2] = 32'hF000_00A5;
    ctl_tbl[3] = 3'b111; exp_tbl[3] = 32'h0F0F_5A5A;
    rst = 1'b0; in_valid = 1'b1; a = 32'hF0F0_A5A5; b = 32'h0FF0_FF00;
    for (int i = 0; i < 4; i++) begin
      ctl = ctl_tbl[i];
      step();
      n_checks++;
      if (out !== exp_tbl[i] || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL mixed ctl=%0d: out=%h v=%b, required out=%h v=1",
                 ctl_tbl[i], out, out_valid, exp_tbl[i]);
      end
    end
    // XOR result 0xFF005AA5 has 16 ones: even parity, not zero, not ones.
    ctl = 3'b010;
    step();
    n_checks++;
    if (parity !== 1'b0 || zero !== 1'b0 || ones !== 1'b0) begin
      n_fail++;
      $display("FAIL mixed_flags: z=%b o=%b p=%b, required z=0 o=0 p=0", zero, ones, parity);
    end
  endtask

  task automatic test_hold();
    rst = 1'b0; in_valid = 1'b1; a = 32'h0000_0026; b = 32'h0000_0001; ctl = 3'b001;
    step();
    n_checks++;
    if (out !== 32'h0000_0027 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_issue: out=%h v=%b, required out=00000027 v=1", out, out_valid);
    end
    // Changing operands while idle must not disturb the held result.
    in_valid = 1'b0; a = 32'h0; b = 32'h0; ctl = 3'b011;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (out !== 32'h0000_0027 || out_valid !== 1'b0 || zero !== 1'b0 ||
          ones !== 1'b0 || parity !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_idle cyc%0d: out=%h v=%b z=%b o=%b p=%b, required out=00000027 v=0 z=0 o=0 p=0",
                 i, out, out_valid, zero, ones, parity);
      end
`ifdef LU_POPCNT_EN
      n_checks++;
      if (popcnt !== 6'd4) begin
        n_fail++;
        $display("FAIL hold_popcnt cyc%0d: got %0d required 4", i, popcnt);
      end
`endif
    end
  endtask

  task automatic test_back_to_back_reset();
    rst = 1'b0; in_valid = 1'b1; a = 32'hF0F0_A5A5; b = 32'h0FF0_FF00; ctl = 3'b010;
    step();
    n_checks++;
    if (out !== 32'hFF00_5AA5 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_op1: out=%h v=%b, required out=ff005aa5 v=1", out, out_valid);
    end
    rst = 1'b1; ctl = 3'b100;
    step();
    n_checks++;
    if (out !== 32'h0 || out_valid !== 1'b0 || zero !== 1'b1 ||
        ones !== 1'b0 || parity !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_reset: out=%h v=%b z=%b o=%b p=%b, required out=0 v=0 z=1 o=0 p=0",
               out, out_valid, zero, ones, parity);
    end
    rst = 1'b0; ctl = 3'b111;
    step();
    n_checks++;
    if (out !== 32'h0F0F_5A5A || out_valid !== 1'b1 || zero !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_after: out=%h v=%b z=%b, required out=0f0f5a5a v=1 z=0",
               out, out_valid, zero);
    end
    in_valid = 1'b0;
    step();
    n_checks++;
    if (out_valid !== 1'b0 || out !== 32'h0F0F_5A5A) begin
      n_fail++;
      $display("FAIL b2b_tail: out=%h v=%b, required out=0f0f5a5a v=0", out, out_valid);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; ctl = '0;
    #1;
    test_reset();
    test_sweep();
    test_flags();
    test_nor_zero();
    test_mixed();
    test_hold();
    test_back_to_back_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
